// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and RAM command codes for the two-requester SPI RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        RESP
    } arb_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester, response and RAM command bus bundle for ram_access_arbiter.
interface ram_access_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req0_valid;
    logic                 req0_rd;
    logic [ADDR_SIZE-1:0] req0_addr;
    logic [ADDR_SIZE-1:0] req0_wdata;
    logic                 req0_ready;
    logic                 req1_valid;
    logic                 req1_rd;
    logic [ADDR_SIZE-1:0] req1_addr;
    logic [ADDR_SIZE-1:0] req1_wdata;
    logic                 req1_ready;
    logic                 resp_valid;
    logic                 resp_id;
    logic                 resp_err;
    logic [ADDR_SIZE-1:0] resp_rdata;
    logic [ADDR_SIZE+1:0] ram_din;
    logic                 ram_rx_valid;
    logic [ADDR_SIZE-1:0] ram_dout;
    logic                 ram_tx_valid;

    modport slave (
        input  req0_valid, req0_rd, req0_addr, req0_wdata,
        input  req1_valid, req1_rd, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_err, resp_rdata,
        output ram_din, ram_rx_valid,
        input  ram_dout, ram_tx_valid
    );

    modport master (
        output req0_valid, req0_rd, req0_addr, req0_wdata,
        output req1_valid, req1_rd, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_err, resp_rdata,
        input  ram_din, ram_rx_valid,
        output ram_dout, ram_tx_valid
    );

endinterface

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the pointer moves to the loser on every accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_id
);

    logic rr_ptr_reg;
    logic rr_ptr_next;

    assign grant_valid = |req;
    // A lone requester always wins; the pointer only breaks ties.
    assign grant_id    = (req == 2'b11) ? rr_ptr_reg : req[1];
    assign rr_ptr_next = accept ? ~grant_id : rr_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the SPI RAM command port between two requesters, expanding each transaction into an addr/data word pair.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    ram_access_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam int CMD_W = ADDR_SIZE + 2;

    arb_state_e           state_reg, state_next;
    logic                 id_reg, id_next;
    logic                 rd_reg, rd_next;
    logic [ADDR_SIZE-1:0] addr_reg, addr_next;
    logic [ADDR_SIZE-1:0] wdata_reg, wdata_next;
    logic [ADDR_SIZE-1:0] rdata_reg, rdata_next;
    logic                 err_reg, err_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    logic [CMD_W-1:0]     ram_din_reg, ram_din_next;
    logic                 ram_rx_valid_reg, ram_rx_valid_next;
    logic                 resp_valid_reg, resp_valid_next;
    logic                 resp_id_reg, resp_id_next;
    logic                 resp_err_reg, resp_err_next;
    logic [ADDR_SIZE-1:0] resp_rdata_reg, resp_rdata_next;

    logic [1:0]           req_valid;
    logic [1:0]           ready;
    logic                 grant_valid;
    logic                 grant_id;
    logic                 accept;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign accept    = (state_reg == IDLE) && grant_valid;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = accept && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready   = ready[0];
    assign bus.req1_ready   = ready[1];
    assign bus.ram_din      = ram_din_reg;
    assign bus.ram_rx_valid = ram_rx_valid_reg;
    assign bus.resp_valid   = resp_valid_reg;
    assign bus.resp_id      = resp_id_reg;
    assign bus.resp_err     = resp_err_reg;
    assign bus.resp_rdata   = resp_rdata_reg;

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        rd_next    = rd_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    id_next    = grant_id;
                    rd_next    = grant_id ? bus.req1_rd    : bus.req0_rd;
                    addr_next  = grant_id ? bus.req1_addr  : bus.req0_addr;
                    wdata_next = grant_id ? bus.req1_wdata : bus.req0_wdata;
                    rdata_next = '0;
                    err_next   = 1'b0;
                    state_next = ADDR;
                end
            end
            ADDR: state_next = DATA;
            DATA: begin
                cnt_next   = '0;
                state_next = rd_reg ? WAIT : RESP;
            end
            WAIT: begin
                if (bus.ram_tx_valid) begin
                    rdata_next = bus.ram_dout;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CNT_W'(RD_TIMEOUT)) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered versions line up with it.
    always_comb begin
        ram_din_next      = '0;
        ram_rx_valid_next = 1'b0;
        resp_valid_next   = 1'b0;
        resp_id_next      = 1'b0;
        resp_err_next     = 1'b0;
        resp_rdata_next   = '0;

        case (state_next)
            ADDR: begin
                ram_rx_valid_next = 1'b1;
                ram_din_next      = {rd_next ? CMD_RD_ADDR : CMD_WR_ADDR, addr_next};
            end
            DATA: begin
                ram_rx_valid_next = 1'b1;
                ram_din_next      = rd_next ? {CMD_RD_DATA, {ADDR_SIZE{1'b0}}}
                                            : {CMD_WR_DATA, wdata_next};
            end
            RESP: begin
                resp_valid_next = 1'b1;
                resp_id_next    = id_next;
                resp_err_next   = err_next;
                resp_rdata_next = rdata_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            id_reg           <= 1'b0;
            rd_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            rdata_reg        <= '0;
            err_reg          <= 1'b0;
            cnt_reg          <= '0;
            ram_din_reg      <= '0;
            ram_rx_valid_reg <= 1'b0;
            resp_valid_reg   <= 1'b0;
            resp_id_reg      <= 1'b0;
            resp_err_reg     <= 1'b0;
            resp_rdata_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            id_reg           <= id_next;
            rd_reg           <= rd_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            rdata_reg        <= rdata_next;
            err_reg          <= err_next;
            cnt_reg          <= cnt_next;
            ram_din_reg      <= ram_din_next;
            ram_rx_valid_reg <= ram_rx_valid_next;
            resp_valid_reg   <= resp_valid_next;
            resp_id_reg      <= resp_id_next;
            resp_err_reg     <= resp_err_next;
            resp_rdata_reg   <= resp_rdata_next;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural SPI RAM model.
module tb_ram_access_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ram_access_arbiter_if #(.ADDR_SIZE(8)) bus ();

    ram_access_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: answers an 11 command one cycle later unless silenced; spur forces tx_valid.
    logic [7:0] mem [256];
    logic [7:0] ram_addr;
    logic       rd_pending;
    logic       ram_silent;
    logic       spur;

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        ram_addr         = 8'h00;
        rd_pending       = 1'b0;
        bus.ram_dout     = 8'h00;
        bus.ram_tx_valid = 1'b0;
    end

    always @(negedge clk) begin
        bus.ram_dout     = rd_pending ? mem[ram_addr] : 8'h00;
        bus.ram_tx_valid = (rd_pending && !ram_silent) || spur;
        rd_pending       = 1'b0;
        if (bus.ram_rx_valid) begin
            case (bus.ram_din[9:8])
                2'b00, 2'b10: ram_addr = bus.ram_din[7:0];
                2'b01:        mem[ram_addr] = bus.ram_din[7:0];
                default:      rd_pending = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drive_req(input logic id, input logic rd, input logic [7:0] addr,
                             input logic [7:0] wdata);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_rd = rd;
            bus.req1_addr  = addr; bus.req1_wdata = wdata;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_rd = rd;
            bus.req0_addr  = addr; bus.req0_wdata = wdata;
        end
    endtask

    // Called right after the accepting edge: checks both command words and the response.
    task automatic finish_txn(input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic exp_id, input logic [7:0] exp_rdata,
                              input logic exp_err, input int exp_lat);
        int n;
        logic [9:0] exp_w;
        @(negedge clk);
        exp_w = {rd, 1'b0, addr};
        chk("addr_word_vld", 32'(bus.ram_rx_valid), 32'd1);
        chk("addr_word", 32'(bus.ram_din), 32'(exp_w));
        @(negedge clk);
        exp_w = rd ? 10'h300 : {2'b01, wdata};
        chk("data_word_vld", 32'(bus.ram_rx_valid), 32'd1);
        chk("data_word", 32'(bus.ram_din), 32'(exp_w));
        n = 2;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.resp_valid && n < 40);
        chk("resp_lat", 32'(n), 32'(exp_lat));
        chk("resp_id", 32'(bus.resp_id), 32'(exp_id));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", 32'(bus.resp_rdata), 32'(exp_rdata));
        chk("resp_rxv_low", 32'(bus.ram_rx_valid), 32'd0);
        $display("txn id=%0d rd=%0d addr=%02h wdata=%02h -> rdata=%02h err=%0d lat=%0d",
                 exp_id, rd, addr, wdata, bus.resp_rdata, bus.resp_err, n);
    endtask

    task automatic run_txn(input logic id, input logic rd, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
        @(negedge clk);
        drive_req(id, rd, addr, wdata);
        #1;
        chk("ready", 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
        @(posedge clk);
        #1 clear_reqs();
        finish_txn(rd, addr, wdata, id, exp_rdata, exp_err, exp_lat);
    endtask

    initial begin
        logic g;
        n_cmp = 0;
        n_bad = 0;
        ram_silent = 1'b0;
        spur       = 1'b0;
        clear_reqs();
        bus.req0_rd = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 8'h00;
        bus.req1_rd = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 8'h00;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_rxv", 32'(bus.ram_rx_valid), 32'd0);
        chk("rst_din", 32'(bus.ram_din), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.resp_rdata), 32'd0);
        rst_n = 1'b1;

        // Single write, then read back through the other requester.
        run_txn(1'b0, 1'b0, 8'h3C, 8'hA5, 8'h00, 1'b0, 3);
        run_txn(1'b1, 1'b1, 8'h3C, 8'h00, 8'hA5, 1'b0, 4);

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 8'h10, 8'h11);
        drive_req(1'b1, 1'b0, 8'h20, 8'h22);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("arb_one_hot", 32'(bus.req0_ready + bus.req1_ready), 32'd1);
            g = bus.req1_ready;
            chk("arb_grant", 32'(g), 32'(k % 2));
            @(posedge clk);
            finish_txn(1'b0, g ? 8'h20 : 8'h10, g ? 8'h22 : 8'h11, g, 8'h00, 1'b0, 3);
        end
        clear_reqs();

        // Read timeout, then a normal transaction is still accepted.
        @(negedge clk);
        ram_silent = 1'b1;
        run_txn(1'b0, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 19);
        @(negedge clk);
        ram_silent = 1'b0;
        run_txn(1'b1, 1'b0, 8'h44, 8'h5A, 8'h00, 1'b0, 3);

        // Spurious tx_valid while idle and during a write.
        @(negedge clk);
        spur = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("spur_idle_resp", 32'(bus.resp_valid), 32'd0);
            chk("spur_idle_rxv", 32'(bus.ram_rx_valid), 32'd0);
        end
        run_txn(1'b0, 1'b0, 8'h55, 8'h66, 8'h00, 1'b0, 3);
        @(negedge clk);
        spur = 1'b0;

        // Reset between the addr and data words of a req0 write.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 8'h77, 8'h88);
        @(posedge clk);
        #1 clear_reqs();
        @(negedge clk);
        chk("mid_addr_vld", 32'(bus.ram_rx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rxv", 32'(bus.ram_rx_valid), 32'd0);
        chk("mid_rst_din", 32'(bus.ram_din), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        drive_req(1'b0, 1'b0, 8'h90, 8'h91);
        drive_req(1'b1, 1'b0, 8'hA0, 8'hA1);
        #1;
        chk("post_rst_r0", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_r1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1 clear_reqs();
        finish_txn(1'b0, 8'h90, 8'h91, 1'b0, 8'h00, 1'b0, 3);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
